// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin front end for one shared ALU
// Optional response hold limit enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_share_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [5:0] req0_a,
  input  logic [5:0] req0_b,
  input  logic [2:0] req0_op,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [5:0] req1_a,
  input  logic [5:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       req1_ready,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [5:0] alu_res,
  input  logic       alu_err,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [5:0] rsp_res,
  output logic       rsp_err,
  input  logic       rsp_ready,
  output logic [5:0] disp_value,
  output logic       disp_err,
  output logic       timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("alu_share_arbiter: TIMEOUT_CYCLES must be in 2..256");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic last_id;
  logic grant_valid;
  logic grant_id;
  logic accept;
  logic timeout_hit;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (accept) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_RESPOND;
      S_RESPOND: if (rsp_ready || timeout_hit) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    if (state == S_IDLE && grant_valid) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
    if (state == S_RESPOND) begin
      rsp_valid = 1'b1;
    end
  end

  assign accept = req0_ready | req1_ready;

  // Operands and requester id latch only on accept; the result and display only in CAPTURE.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id     <= 1'b0;
      last_id    <= 1'b1;
      rsp_res    <= '0;
      rsp_err    <= 1'b0;
      disp_value <= '0;
      disp_err   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= grant_id ? req1_a  : req0_a;
        alu_b   <= grant_id ? req1_b  : req0_b;
        alu_op  <= grant_id ? req1_op : req0_op;
        rsp_id  <= grant_id;
        last_id <= grant_id;
      end
      if (state == S_CAPTURE) begin
        rsp_res    <= alu_res;
        rsp_err    <= alu_err;
        disp_value <= alu_res;
        disp_err   <= alu_err;
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] to_cnt;
  logic          timeout_q;

  // A handshake in the limit cycle wins because the hit term requires !rsp_ready.
  assign timeout_hit = (state == S_RESPOND) && !rsp_ready &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == S_RESPOND && !rsp_ready && !timeout_hit) begin
        to_cnt <= to_cnt + CW'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed table-driven bench for alu_share_arbiter
// Define ALU_ARB_TIMEOUT_EN to also exercise the response hold limit (TIMEOUT_CYCLES=4).
module tb_alu_share_arbiter;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
  localparam int STALL  = 3;
`else
  localparam int TO_CYC = 256;
  localparam int STALL  = 10;
`endif

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [5:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       req0_ready, req1_ready;
  logic [5:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       alu_err;
  logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [5:0] rsp_res, disp_value;
  logic       disp_err, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_100MHz(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .disp_value(disp_value), .disp_err(disp_err), .timeout(timeout)
  );

  // Shared ALU stand-in: signed 6-bit arithmetic with overflow flag.
  always_comb begin
    alu_res = alu_a;
    alu_err = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = alu_a + alu_b;
        alu_err = (alu_a[5] == alu_b[5]) && (alu_res[5] != alu_a[5]);
      end
      OP_SUB: begin
        alu_res = alu_a - alu_b;
        alu_err = (alu_a[5] != alu_b[5]) && (alu_res[5] != alu_a[5]);
      end
      OP_AND:  alu_res = alu_a & alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      default: alu_res = alu_a;
    endcase
  end

  typedef struct {
    logic       id;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic [5:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [5:0] a,
                         input logic [5:0] b, input logic [2:0] op);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int seen;
    logic got_id;

    vecs[0] = '{1'b0, 6'h05, 6'h03, OP_ADD, 6'h08, 1'b0};
    vecs[1] = '{1'b1, 6'h1F, 6'h01, OP_ADD, 6'h20, 1'b1};
    vecs[2] = '{1'b0, 6'h20, 6'h01, OP_SUB, 6'h1F, 1'b1};
    vecs[3] = '{1'b1, 6'h0A, 6'h03, OP_SUB, 6'h07, 1'b0};
    vecs[4] = '{1'b0, 6'h3C, 6'h0F, OP_AND, 6'h0C, 1'b0};
    vecs[5] = '{1'b1, 6'h2A, 6'h15, OP_XOR, 6'h3F, 1'b0};
    vecs[6] = '{1'b0, 6'h3E, 6'h3D, OP_ADD, 6'h3B, 1'b0};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_res", rsp_res, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_disp", {disp_err, disp_value}, 0);
    chk("reset_timeout", timeout, 0);
    rst = 1'b0;
    #1;

    // Single-requester vectors with an always-ready consumer.
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      chk("vec_ready", {req1_ready, req0_ready}, vecs[i].id ? 2'b10 : 2'b01);
      tick();
      set_req(vecs[i].id, 1'b0, 6'h00, 6'h00, 3'd0);
      chk("vec_alu_a", alu_a, vecs[i].a);
      chk("vec_alu_op", alu_op, vecs[i].op);
      tick();
      chk("vec_issue_no_rsp", rsp_valid, 0);
      tick();
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_id", rsp_id, vecs[i].id);
      chk("vec_rsp_res", rsp_res, vecs[i].res);
      chk("vec_rsp_err", rsp_err, vecs[i].err);
      chk("vec_disp", {disp_err, disp_value}, {vecs[i].err, vecs[i].res});
      tick();
      chk("vec_rsp_done", rsp_valid, 0);
    end

    // Both requesters valid from reset: grants alternate starting with req0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b1, 6'h01, 6'h01, OP_ADD);
    set_req(1'b1, 1'b1, 6'h02, 6'h02, OP_ADD);
    #1;
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int c = 0; c < 8 && seen == 0; c++) begin
        if (req0_ready && req1_ready) chk("rr_overlap", 2'b11, 2'b00);
        if (req0_ready || req1_ready) begin
          got_id = req1_ready;
          chk("rr_grant", got_id, k % 2);
          seen = 1;
        end
        tick();
      end
      if (seen == 0) chk("rr_grant_timeout", 0, 1);
    end
    drain();

    // Consumer back-pressure holds the response and blocks new requests.
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 6'h05, 6'h03, OP_ADD);
    #1;
    tick();
    set_req(1'b0, 1'b0, 6'h00, 6'h00, 3'd0);
    set_req(1'b1, 1'b1, 6'h00, 6'h00, OP_ADD);
    repeat (2) tick();
    chk("hold_rsp_valid", rsp_valid, 1);
    for (int c = 0; c < STALL; c++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_res", {rsp_id, rsp_err, rsp_res}, {1'b0, 1'b0, 6'h08});
      chk("hold_readys", {req1_ready, req0_ready}, 0);
      chk("hold_no_timeout", timeout, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("release_valid", rsp_valid, 0);
    chk("release_idle_grant", req1_ready, 1);
    tick();
    drain();

    // Reset while the operation sits in ISSUE.
    set_req(1'b0, 1'b1, 6'h07, 6'h07, OP_ADD);
    #1;
    tick();
    set_req(1'b0, 1'b0, 6'h00, 6'h00, 3'd0);
    rst = 1'b1;
    #1;
    chk("midrst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_disp", {disp_err, disp_value}, 0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("postrst_no_rsp", rsp_valid, 0);
    end
    chk("postrst_disp", disp_value, 0);
    set_req(1'b0, 1'b1, 6'h01, 6'h02, OP_ADD);
    #1;
    chk("postrst_ready", req0_ready, 1);
    tick();
    drain();
    chk("postrst_disp_after_op", disp_value, 6'h03);

`ifdef ALU_ARB_TIMEOUT_EN
    // Response dropped after the hold limit with a one-cycle timeout pulse.
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 6'h0A, 6'h03, OP_SUB);
    #1;
    tick();
    set_req(1'b1, 1'b0, 6'h00, 6'h00, 3'd0);
    repeat (2) tick();
    chk("to_rsp_valid", rsp_valid, 1);
    repeat (3) begin
      tick();
      chk("to_still_valid", {rsp_valid, timeout}, 2'b10);
    end
    tick();
    chk("to_drop", {rsp_valid, timeout}, 2'b01);
    chk("to_disp_kept", disp_value, 6'h07);
    tick();
    chk("to_pulse_end", timeout, 0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, response hold limit in clocks (used only under ALU_ARB_TIMEOUT_EN); legal range 2..256.
REQ-002 Clock and reset: one clock, clk_100MHz; reset is asynchronous and active-high, rst.
REQ-003 clk_100MHz  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester N holds a valid operation.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  6  two's-complement operands.
REQ-007 req0_op / req1_op  input  3  ALU opcode.
REQ-008 req0_ready / req1_ready  output  1  requester N accepted this cycle when valid&ready.
REQ-009 alu_a, alu_b  output  6  registered operands to the shared ALU; alu_op  output  3  registered opcode.
REQ-010 alu_res  input  6  ALU result (combinational from alu_a/alu_b/alu_op); alu_err  input  1  ALU overflow/underflow flag.
REQ-011 rsp_valid  output  1; rsp_id  output  1 (requester index); rsp_res  output  6; rsp_err  output  1.
REQ-012 rsp_ready  input  1  consumer accepts response when rsp_valid&rsp_ready.
REQ-013 disp_value  output  6, disp_err  output  1  last completed result/error, held for the seven-segment display.
REQ-014 timeout  output  1  one-cycle pulse on response drop.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPTURE, RESPOND; exactly one operation outstanding.
REQ-016 IDLE: reqN_ready = 1 only for granted N, combinational; both readys never high together.
REQ-017 Grant: one valid -> that requester; both valid -> requester not granted last (round-robin); none -> no grant.
REQ-018 Round-robin pointer updates only on an accepted handshake.
REQ-019 Accept at edge E: alu_a/alu_b/alu_op, rsp_id registered; state -> ISSUE.
REQ-020 ISSUE: one cycle for ALU settling; -> CAPTURE unconditionally.
REQ-021 CAPTURE: alu_res/alu_err registered into rsp_res/rsp_err and disp_value/disp_err; rsp_valid set; -> RESPOND. rsp_valid first high after edge E+2.
REQ-022 RESPOND: rsp_valid, rsp_id, rsp_res, rsp_err stable until handshake; on rsp_valid&rsp_ready -> IDLE, rsp_valid cleared same edge.
REQ-023 reqN_ready = 0 in ISSUE, CAPTURE, RESPOND; new requests wait, no back-to-back overlap (throughput 1 op per ≥4 cycles).
REQ-024 alu_a/alu_b/alu_op hold last issued values outside accept edges.
REQ-025 disp_value/disp_err change only in CAPTURE; unaffected by rsp handshake or timeout.
REQ-026 Requester deasserting valid while not ready: no effect, no grant.
REQ-027 rsp_ready asserted while rsp_valid = 0: ignored.

Reset
REQ-028 rst asserted: state IDLE, rsp_valid 0, rsp_id 0, rsp_res 0, rsp_err 0, alu_a/alu_b/alu_op 0, disp_value 0, disp_err 0, timeout 0, pointer set so req0 wins first contention, timeout counter 0.
REQ-029 Reset mid-operation: in-flight operation discarded, no response, display not updated.
REQ-030 After rst deasserts, first accept possible on first rising edge.

Configuration
REQ-031 Macro ALU_ARB_TIMEOUT_EN defined: counter runs in RESPOND; after TIMEOUT_CYCLES cycles with rsp_valid high and no rsp_ready, rsp_valid clears, timeout pulses 1 cycle, state -> IDLE.
REQ-032 Handshake in the same cycle the limit is reached takes priority; no timeout pulse.
REQ-033 ALU_ARB_TIMEOUT_EN undefined: no counter, RESPOND waits indefinitely, timeout tied 0.

Verification
REQ-034 req0 only, a=5, b=3, op=ADD, rsp_ready=1 -> rsp_valid after E+2, rsp_id=0, rsp_res=8, rsp_err=0, disp_value=8.
REQ-035 Both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; no ready overlap.
REQ-036 req1 a=31, b=1, op=ADD -> rsp_res=-32 (6'b100000), rsp_err=1, disp_err=1.
REQ-037 rsp_ready=0 for 10 cycles -> rsp outputs stable, req readys 0; release -> IDLE next edge.
REQ-038 rst pulsed in ISSUE -> all outputs 0, no rsp_valid, disp_value unchanged from 0.
REQ-039 ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, rsp_ready=0 -> rsp_valid drops after 4 cycles, timeout one-cycle pulse, disp_value retained.
